// File: rtl/fetch_mem_unit.sv
// Memory-access stage: owns PC and IR, sequences instruction fetches and LDR/STR
// accesses over a ready-handshake memory port, with a sticky bus-timeout fault.
module fetch_mem_unit #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_next_in,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr_in,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IFETCH,
    S_DACCESS,
    S_FAULT
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // NOTE: every _d gets a default before the case, so no path leaves a signal
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    fault_d = fault_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (pc_load) pc_d = pc_next_in;
        // Fetch wins over a simultaneous data request; the loser is dropped.
        if (fetch_start) begin
          state_d = S_IFETCH;
          cmd_d   = CMD_READ;
          addr_d  = pc_load ? pc_next_in : pc_q;
        end else if (data_req) begin
          state_d = S_DACCESS;
          cmd_d   = data_we ? CMD_WRITE : CMD_READ;
          addr_d  = data_addr_in;
          wdata_d = data_wdata;
        end
      end

      S_IFETCH, S_DACCESS: begin
        if (mem_ready) begin
          if (state_q == S_IFETCH) begin
            ir_d = mem_rdata;
            pc_d = pc_q + 1'b1;
          end else if (cmd_q == CMD_READ) begin
            rdata_d = mem_rdata;
          end
          done_d  = 1'b1;
          cmd_d   = CMD_NONE;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state_d = S_FAULT;
            cmd_d   = CMD_NONE;
            fault_d = 1'b1;
          end
        end
      end

      S_FAULT: begin
        // Absorbing: only reset leaves this state.
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_cmd   = cmd_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed bench for fetch_mem_unit: a small RAM model with programmable wait
// states drives the memory port; each scenario task checks hand-computed values.
module tb_fetch_mem_unit;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  logic              clk;
  logic              reset;
  logic              fetch_start;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next_in;
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr_in;
  logic [DATA_W-1:0] data_wdata;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              busy;
  logic              fault;

  int tests;
  int fails;

  // RAM model: ready after wait_cfg stalled cycles; ready_ovr forces ready high.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int   wait_cfg;
  int   wait_cnt;
  logic ready_ovr;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = ready_ovr | ((mem_cmd != 2'b00) && (wait_cnt >= wait_cfg));

  always @(posedge clk) begin
    if (mem_cmd != 2'b00 && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (mem_cmd == 2'b10 && mem_ready) mem[mem_addr] <= mem_wdata;
  end

  fetch_mem_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_start(fetch_start), .pc_load(pc_load), .pc_next_in(pc_next_in),
    .data_req(data_req), .data_we(data_we), .data_addr_in(data_addr_in),
    .data_wdata(data_wdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .ir(ir), .rdata(rdata), .done(done), .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    tests++; if (pc !== 9'd0)      begin fails++; $display("FAIL rst_pc got=%0h exp=0", pc); end
    tests++; if (ir !== 16'h0)     begin fails++; $display("FAIL rst_ir got=%0h exp=0", ir); end
    tests++; if (rdata !== 16'h0)  begin fails++; $display("FAIL rst_rdata got=%0h exp=0", rdata); end
    tests++; if (mem_cmd !== 2'b00) begin fails++; $display("FAIL rst_cmd got=%0b exp=00", mem_cmd); end
    tests++; if (mem_addr !== 9'd0) begin fails++; $display("FAIL rst_addr got=%0h exp=0", mem_addr); end
    tests++; if (mem_wdata !== 16'h0) begin fails++; $display("FAIL rst_wdata got=%0h exp=0", mem_wdata); end
    tests++; if ({done, busy, fault} !== 3'b000) begin fails++; $display("FAIL rst_flags got=%0b exp=000", {done, busy, fault}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    @(negedge clk); fetch_start = 1'b1;
    @(negedge clk); fetch_start = 1'b0;
    tests++; if (mem_cmd !== 2'b01) begin fails++; $display("FAIL fetch_cmd got=%0b exp=01", mem_cmd); end
    tests++; if (mem_addr !== 9'd0) begin fails++; $display("FAIL fetch_addr got=%0h exp=0", mem_addr); end
    tests++; if ({busy, done} !== 2'b10) begin fails++; $display("FAIL fetch_busy got=%0b exp=10", {busy, done}); end
    @(negedge clk);
    tests++; if (done !== 1'b1)    begin fails++; $display("FAIL fetch_done got=%0b exp=1", done); end
    tests++; if (ir !== 16'hD003)  begin fails++; $display("FAIL fetch_ir got=%0h exp=d003", ir); end
    tests++; if (pc !== 9'd1)      begin fails++; $display("FAIL fetch_pc got=%0h exp=1", pc); end
    tests++; if ({mem_cmd, busy} !== 3'b000) begin fails++; $display("FAIL fetch_idle got=%0b exp=000", {mem_cmd, busy}); end
    @(negedge clk);
    tests++; if (done !== 1'b0)    begin fails++; $display("FAIL fetch_done_pulse got=%0b exp=0", done); end
  endtask

  task automatic test_wait_states();
    wait_cfg = 3;
    @(negedge clk); fetch_start = 1'b1;
    @(negedge clk); fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if ({mem_cmd, mem_addr} !== {2'b01, 9'd1}) begin fails++; $display("FAIL wait_hold[%0d] got=%0b/%0h exp=01/1", i, mem_cmd, mem_addr); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL wait_early_done[%0d] got=%0b exp=0", i, done); end
      @(negedge clk);
    end
    tests++; if (done !== 1'b1)   begin fails++; $display("FAIL wait_done got=%0b exp=1", done); end
    tests++; if (ir !== 16'h1111) begin fails++; $display("FAIL wait_ir got=%0h exp=1111", ir); end
    tests++; if (pc !== 9'd2)     begin fails++; $display("FAIL wait_pc got=%0h exp=2", pc); end
    wait_cfg = 0;
  endtask

  task automatic test_data_rw();
    @(negedge clk); data_req = 1'b1; data_we = 1'b0; data_addr_in = 9'd3;
    @(negedge clk); data_req = 1'b0;
    tests++; if ({mem_cmd, mem_addr} !== {2'b01, 9'd3}) begin fails++; $display("FAIL ldr_port got=%0b/%0h exp=01/3", mem_cmd, mem_addr); end
    @(negedge clk);
    tests++; if (done !== 1'b1)    begin fails++; $display("FAIL ldr_done got=%0b exp=1", done); end
    tests++; if (rdata !== 16'h0007) begin fails++; $display("FAIL ldr_rdata got=%0h exp=0007", rdata); end
    tests++; if ({pc, ir} !== {9'd2, 16'h1111}) begin fails++; $display("FAIL ldr_pc_ir got=%0h/%0h exp=2/1111", pc, ir); end

    data_req = 1'b1; data_we = 1'b1; data_addr_in = 9'd5; data_wdata = 16'hBEEF;
    @(negedge clk); data_req = 1'b0;
    tests++; if (mem_cmd !== 2'b10)     begin fails++; $display("FAIL str_cmd got=%0b exp=10", mem_cmd); end
    tests++; if (mem_wdata !== 16'hBEEF) begin fails++; $display("FAIL str_wdata got=%0h exp=beef", mem_wdata); end
    tests++; if (mem_addr !== 9'd5)     begin fails++; $display("FAIL str_addr got=%0h exp=5", mem_addr); end
    @(negedge clk);
    tests++; if (done !== 1'b1)      begin fails++; $display("FAIL str_done got=%0b exp=1", done); end
    tests++; if (rdata !== 16'h0007) begin fails++; $display("FAIL str_rdata got=%0h exp=0007", rdata); end
    tests++; if (mem[5] !== 16'hBEEF) begin fails++; $display("FAIL str_mem got=%0h exp=beef", mem[5]); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); fetch_start = 1'b1;
    @(negedge clk); fetch_start = 1'b0;
    @(negedge clk);
    tests++; if ({done, ir, pc} !== {1'b1, 16'h2222, 9'd3}) begin fails++; $display("FAIL b2b_first got=%0b/%0h/%0h exp=1/2222/3", done, ir, pc); end
    fetch_start = 1'b1;
    @(negedge clk); fetch_start = 1'b0;
    tests++; if ({mem_cmd, mem_addr, done} !== {2'b01, 9'd3, 1'b0}) begin fails++; $display("FAIL b2b_issue got=%0b/%0h/%0b exp=01/3/0", mem_cmd, mem_addr, done); end
    @(negedge clk);
    tests++; if ({done, ir, pc} !== {1'b1, 16'h0007, 9'd4}) begin fails++; $display("FAIL b2b_second got=%0b/%0h/%0h exp=1/0007/4", done, ir, pc); end
  endtask

  task automatic test_branch_wrap();
    @(negedge clk); fetch_start = 1'b1; pc_load = 1'b1; pc_next_in = 9'd511;
    @(negedge clk); fetch_start = 1'b0; pc_load = 1'b0;
    tests++; if (mem_addr !== 9'd511) begin fails++; $display("FAIL br_addr got=%0h exp=1ff", mem_addr); end
    @(negedge clk);
    tests++; if ({done, ir, pc} !== {1'b1, 16'h1234, 9'd0}) begin fails++; $display("FAIL br_wrap got=%0b/%0h/%0h exp=1/1234/0", done, ir, pc); end

    fetch_start = 1'b1; data_req = 1'b1; data_we = 1'b1; data_addr_in = 9'd5; data_wdata = 16'hAAAA;
    @(negedge clk); fetch_start = 1'b0; data_req = 1'b0;
    tests++; if ({mem_cmd, mem_addr} !== {2'b01, 9'd0}) begin fails++; $display("FAIL prio_port got=%0b/%0h exp=01/0", mem_cmd, mem_addr); end
    @(negedge clk);
    tests++; if ({done, ir, pc} !== {1'b1, 16'hD003, 9'd1}) begin fails++; $display("FAIL prio_fetch got=%0b/%0h/%0h exp=1/d003/1", done, ir, pc); end
    tests++; if (mem[5] !== 16'hBEEF) begin fails++; $display("FAIL prio_nowrite got=%0h exp=beef", mem[5]); end
    @(negedge clk);
    tests++; if ({busy, mem_cmd} !== 3'b000) begin fails++; $display("FAIL prio_dropped got=%0b exp=000", {busy, mem_cmd}); end
  endtask

  task automatic test_timeout();
    wait_cfg = 1000;
    @(negedge clk); fetch_start = 1'b1;
    @(negedge clk); fetch_start = 1'b0;
    for (int i = 1; i < 15; i++) begin
      @(negedge clk);
      tests++; if ({fault, done} !== 2'b00) begin fails++; $display("FAIL to_early[%0d] got=%0b exp=00", i, {fault, done}); end
    end
    tests++; if (mem_cmd !== 2'b01) begin fails++; $display("FAIL to_cmd_held got=%0b exp=01", mem_cmd); end
    @(negedge clk);
    tests++; if ({fault, busy, done} !== 3'b110) begin fails++; $display("FAIL to_fault got=%0b exp=110", {fault, busy, done}); end
    tests++; if (mem_cmd !== 2'b00) begin fails++; $display("FAIL to_cmd got=%0b exp=00", mem_cmd); end
    tests++; if ({ir, pc} !== {16'hD003, 9'd1}) begin fails++; $display("FAIL to_state got=%0h/%0h exp=d003/1", ir, pc); end
    ready_ovr = 1'b1; fetch_start = 1'b1; data_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if ({fault, busy, done, mem_cmd, pc} !== {3'b110, 2'b00, 9'd1}) begin fails++; $display("FAIL to_absorb[%0d] got=%0b/%0b/%0b/%0b/%0h exp=1/1/0/00/1", i, fault, busy, done, mem_cmd, pc); end
    end
    fetch_start = 1'b0; data_req = 1'b0;
    reset = 1'b0; #1;
    tests++; if ({fault, busy, pc} !== {2'b00, 9'd0}) begin fails++; $display("FAIL to_reset got=%0b/%0b/%0h exp=0/0/0", fault, busy, pc); end
    @(negedge clk); reset = 1'b1; ready_ovr = 1'b0; wait_cfg = 0;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk); pc_load = 1'b1; pc_next_in = 9'd7;
    @(negedge clk); pc_load = 1'b0;
    tests++; if (pc !== 9'd7) begin fails++; $display("FAIL mid_pcload got=%0h exp=7", pc); end
    wait_cfg = 1000;
    data_req = 1'b1; data_we = 1'b0; data_addr_in = 9'd3;
    @(negedge clk); data_req = 1'b0;
    tests++; if ({busy, mem_cmd} !== 3'b101) begin fails++; $display("FAIL mid_issue got=%0b exp=101", {busy, mem_cmd}); end
    @(negedge clk);
    reset = 1'b0; #1;
    tests++; if ({busy, mem_cmd, done} !== 4'b0000) begin fails++; $display("FAIL mid_abort got=%0b exp=0000", {busy, mem_cmd, done}); end
    tests++; if ({pc, rdata, ir, mem_addr} !== {9'd0, 16'h0, 16'h0, 9'd0}) begin fails++; $display("FAIL mid_regs got=%0h/%0h/%0h/%0h exp=0/0/0/0", pc, rdata, ir, mem_addr); end
    @(negedge clk); reset = 1'b1; wait_cfg = 0; ready_ovr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if ({done, busy, rdata} !== {2'b00, 16'h0}) begin fails++; $display("FAIL mid_nodone[%0d] got=%0b/%0b/%0h exp=0/0/0", i, done, busy, rdata); end
    end
    ready_ovr = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0; fetch_start = 1'b0; pc_load = 1'b0; pc_next_in = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr_in = '0; data_wdata = '0;
    wait_cfg = 0; ready_ovr = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0;
    mem[0] = 16'hD003; mem[1] = 16'h1111; mem[2] = 16'h2222;
    mem[3] = 16'h0007; mem[511] = 16'h1234;

    test_reset();
    test_fetch();
    test_wait_states();
    test_data_rw();
    test_back_to_back();
    test_branch_wrap();
    test_timeout();
    test_reset_mid_access();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
